// File: rtl/dmem_responder_if.sv
// Bus between the MEM-stage datapath and the data-memory responder.
// master : datapath side. It drives the request fields and holds req_i until ready_o.
// slave  : responder side. It returns rdata_o, ready_o, busy_o and addr_err_o.
// Signal names keep the _i/_o suffixes as seen from the responder.
interface dmem_responder_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        sign_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        busy_o;
    logic        addr_err_o;

    modport master (
        output req_i, we_i, size_i, sign_i, addr_i, wdata_i,
        input  rdata_o, ready_o, busy_o, addr_err_o
    );

    modport slave (
        input  req_i, we_i, size_i, sign_i, addr_i, wdata_i,
        output rdata_o, ready_o, busy_o, addr_err_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage of the pipelined MIPS core.
// The responder accepts one load or store at a time. It waits WAIT_CYCLES extra
// cycles, then commits the access and raises ready_o for exactly one cycle.
// Stores merge only the selected byte lanes. Loads extract the selected lanes and
// zero- or sign-extend them. Misaligned or illegal accesses skip the memory and
// complete on the next cycle with addr_err_o set.
// Ports:
//   clk  : clock; all state changes on the rising edge
//   rst  : asynchronous active-low reset
//   bus  : dmem_responder_if.slave
//          request fields : req_i, we_i, size_i, sign_i, addr_i, wdata_i
//          result fields  : rdata_o, ready_o, busy_o, addr_err_o
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam bit       ZERO_WAIT = (WAIT_CYCLES == 0);
    // This value is only loaded when WAIT_CYCLES > 0, so it cannot wrap in use.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    // Returns 1 when the size/offset combination cannot be serviced.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            2'b00:   res = 1'b0;
            2'b01:   res = off[0];
            2'b10:   res = (off != 2'b00);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    // Replaces only the addressed byte lanes of old_word with right-aligned store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [3:0]  be;
        logic [31:0] lanes;
        logic [31:0] res;
        case (size)
            2'b00: begin
                be    = 4'b0001 << off;
                lanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {off[1], 1'b0};
                lanes = {2{wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                lanes = wdata;
            end
        endcase
        res = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                res[8*k +: 8] = lanes[8*k +: 8];
            end else begin
                res[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    // Picks the addressed byte or half and extends it to 32 bits. Word loads pass through unchanged.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic        sign,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = {{24{sign & b[7]}}, b};
            2'b01:   res = {{16{sign & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                lat_we_q;
    logic [1:0]          lat_size_q;
    logic                lat_sign_q;
    logic [ADDR_W+1:0]   lat_addr_q;
    logic [31:0]         lat_wdata_q;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                ready_q;
    logic                busy_q;
    logic [31:0]         mem_q [0:(1<<ADDR_W)-1];

    logic                latch_s;
    logic                commit_s;
    logic                mis_s;
    logic                live_s;
    logic                acc_we_s;
    logic [1:0]          acc_size_s;
    logic                acc_sign_s;
    logic [ADDR_W+1:0]   acc_addr_s;
    logic [31:0]         acc_wdata_s;
    logic [ADDR_W-1:0]   word_idx_s;
    logic [31:0]         mem_rd_s;
    logic [31:0]         mem_wdata_s;
    logic                unused_addr_s;

    // Address bits above the memory span wrap around. They are never looked at.
    assign unused_addr_s = ^bus.addr_i[31:ADDR_W+2];

    // A zero-wait commit happens in IDLE and uses the live inputs. Otherwise the latched copy is used.
    assign live_s      = (state_q == ST_IDLE);
    assign acc_we_s    = live_s ? bus.we_i              : lat_we_q;
    assign acc_size_s  = live_s ? bus.size_i            : lat_size_q;
    assign acc_sign_s  = live_s ? bus.sign_i            : lat_sign_q;
    assign acc_addr_s  = live_s ? bus.addr_i[ADDR_W+1:0] : lat_addr_q;
    assign acc_wdata_s = live_s ? bus.wdata_i           : lat_wdata_q;
    assign word_idx_s  = acc_addr_s[ADDR_W+1:2];
    assign mem_rd_s    = mem_q[word_idx_s];
    assign mem_wdata_s = store_merge(mem_rd_s, acc_wdata_s, acc_size_s, acc_addr_s[1:0]);
    assign mis_s       = misaligned(bus.size_i, bus.addr_i[1:0]);

    // Next state, wait counter, commit strobe and the next result values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        commit_s = 1'b0;
        latch_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    latch_s = 1'b1;
                    if (mis_s) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'h0000_0000;
                    end else if (ZERO_WAIT) begin
                        commit_s = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit_s = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (commit_s) begin
            err_d = 1'b0;
            if (!acc_we_s) begin
                rdata_d = load_extract(mem_rd_s, acc_size_s, acc_sign_s, acc_addr_s[1:0]);
            end else begin
                rdata_d = rdata_q;
            end
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            lat_we_q    <= 1'b0;
            lat_size_q  <= 2'b00;
            lat_sign_q  <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= 32'h0000_0000;
            rdata_q     <= 32'h0000_0000;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
            if (latch_s) begin
                lat_we_q    <= bus.we_i;
                lat_size_q  <= bus.size_i;
                lat_sign_q  <= bus.sign_i;
                lat_addr_q  <= bus.addr_i[ADDR_W+1:0];
                lat_wdata_q <= bus.wdata_i;
            end
        end
    end

    // Memory write port. The rst term keeps a store from landing while reset is held.
    always_ff @(posedge clk) begin
        if (rst && commit_s && acc_we_s) begin
            mem_q[word_idx_s] <= mem_wdata_s;
        end
    end

    assign bus.rdata_o    = rdata_q;
    assign bus.ready_o    = ready_q;
    assign bus.busy_o     = busy_q;
    assign bus.addr_err_o = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    dmem_responder_if i0 ();
    dmem_responder_if i1 ();

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u0 (.clk(clk), .rst(rst), .bus(i0));
    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u1 (.clk(clk), .rst(rst), .bus(i1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference model: byte-addressed memory plus one outstanding access per DUT
    logic [7:0]  mb [int];
    int          wait_of [2] = '{2, 0};
    bit          pend [2];
    int          due [2];
    bit          exp_err [2];
    logic [31:0] exp_rd [2];
    bit          chk_rd [2];
    bit          st_we [2];
    logic [31:0] st_addr [2];
    logic [31:0] st_data [2];
    int          st_n [2];

    function automatic int key(input int id, input logic [31:0] a);
        return id * 65536 + int'(a[AW+1:0]);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input int id);
        return (id == 0) ? i0.rdata_o : i1.rdata_o;
    endfunction
    function automatic logic [31:0] er(input int id);
        return (id == 0) ? 32'(i0.addr_err_o) : 32'(i1.addr_err_o);
    endfunction

    task automatic drive(input int id, input bit req, input bit we, input logic [1:0] size,
                         input bit sign, input logic [31:0] addr, input logic [31:0] wdata);
        if (id == 0) begin
            i0.req_i = req; i0.we_i = we; i0.size_i = size; i0.sign_i = sign;
            i0.addr_i = addr; i0.wdata_i = wdata;
        end else begin
            i1.req_i = req; i1.we_i = we; i1.size_i = size; i1.sign_i = sign;
            i1.addr_i = addr; i1.wdata_i = wdata;
        end
    endtask

    task automatic set_req(input int id, input bit v);
        if (id == 0) i0.req_i = v; else i1.req_i = v;
    endtask

    // Compare one DUT's outputs with the model on every cycle
    task automatic cmp(input int id, input logic rdy, input logic bsy, input logic err, input logic [31:0] rdv);
        bit exp_rdy;
        exp_rdy = pend[id] && (cyc == due[id]);
        check($sformatf("ready%0d", id), 32'(rdy), 32'(exp_rdy));
        check($sformatf("busy%0d", id), 32'(bsy), 32'(pend[id]));
        if (exp_rdy) begin
            check($sformatf("err%0d", id), 32'(err), 32'(exp_err[id]));
            if (chk_rd[id]) check($sformatf("rdata%0d", id), rdv, exp_rd[id]);
            if (st_we[id]) begin
                for (int i = 0; i < st_n[id]; i++)
                    mb[key(id, st_addr[id] + 32'(i))] = st_data[id][8*i +: 8];
            end
            pend[id] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cmp(0, i0.ready_o, i0.busy_o, i0.addr_err_o, i0.rdata_o);
            cmp(1, i1.ready_o, i1.busy_o, i1.addr_err_o, i1.rdata_o);
        end
    end

    // Issue a request. At acceptance, record what the completion must look like.
    task automatic start(input int id, input bit we, input logic [1:0] size, input bit sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        logic [31:0] v;
        bit mis;
        @(negedge clk);
        drive(id, 1'b1, we, size, sign, addr, wdata);
        @(posedge clk);
        #1;
        mis = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        n = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
        pend[id] = 1'b1;
        st_we[id] = 1'b0;
        chk_rd[id] = 1'b1;
        if (mis) begin
            due[id] = cyc;
            exp_err[id] = 1'b1;
            exp_rd[id] = 32'h0;
        end else begin
            due[id] = cyc + wait_of[id];
            exp_err[id] = 1'b0;
            if (we) begin
                st_we[id] = 1'b1; st_addr[id] = addr; st_data[id] = wdata; st_n[id] = n;
                chk_rd[id] = 1'b0;
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(mb[key(id, addr + 32'(i))]) << (8*i));
                if (n < 4 && sign && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                exp_rd[id] = v;
            end
        end
    endtask

    // Wait until the model's completion cycle, then drop req. With hold set, req stays high through DONE.
    task automatic finish(input int id, input bit hold);
        @(negedge clk);
        while (cyc < due[id]) @(negedge clk);
        if (hold) begin
            @(posedge clk);
            #1;
        end
        set_req(id, 1'b0);
    endtask

    task automatic access(input int id, input bit we, input logic [1:0] size, input bit sign,
                          input logic [31:0] addr, input logic [31:0] wdata);
        start(id, we, size, sign, addr, wdata);
        finish(id, 1'b0);
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_ready0", 32'(i0.ready_o), 32'h0);
        check("rst_busy0",  32'(i0.busy_o), 32'h0);
        check("rst_err0",   32'(i0.addr_err_o), 32'h0);
        check("rst_rdata0", i0.rdata_o, 32'h0);
        check("rst_ready1", 32'(i1.ready_o), 32'h0);
        check("rst_rdata1", i1.rdata_o, 32'h0);
        @(posedge clk); #2 rst = 1'b1;

        // Word store, then word load
        access(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344);
        access(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        check("lit_lw1", rd(0), 32'h1122_3344);
        check("lit_err1", er(0), 32'h0);

        // Byte and half stores merge into the existing word
        access(0, 1'b1, 2'd0, 1'b0, 32'h102, 32'h0000_00AA);
        access(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        check("lit_sb", rd(0), 32'h11AA_3344);
        access(0, 1'b1, 2'd1, 1'b0, 32'h100, 32'h0000_BEEF);
        access(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        check("lit_sh", rd(0), 32'h11AA_BEEF);

        // Sign and zero extension
        access(0, 1'b1, 2'd2, 1'b0, 32'h104, 32'h80FF_7F00);
        access(0, 1'b0, 2'd0, 1'b1, 32'h107, 32'h0);
        check("lit_lb3", rd(0), 32'hFFFF_FF80);
        access(0, 1'b0, 2'd0, 1'b0, 32'h107, 32'h0);
        check("lit_lbu3", rd(0), 32'h0000_0080);
        access(0, 1'b0, 2'd0, 1'b1, 32'h105, 32'h0);
        check("lit_lb1", rd(0), 32'h0000_007F);
        access(0, 1'b0, 2'd1, 1'b1, 32'h106, 32'h0);
        check("lit_lh2", rd(0), 32'hFFFF_80FF);
        access(0, 1'b0, 2'd1, 1'b0, 32'h106, 32'h0);
        check("lit_lhu2", rd(0), 32'h0000_80FF);

        // Misaligned and illegal accesses
        access(0, 1'b1, 2'd2, 1'b0, 32'h101, 32'hDEAD_BEEF);
        check("lit_mis_err", er(0), 32'h1);
        check("lit_mis_rd", rd(0), 32'h0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        check("lit_after_mis", rd(0), 32'h11AA_BEEF);
        access(0, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        check("lit_size3_err", er(0), 32'h1);
        access(0, 1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);

        // Addresses wrap modulo the memory span
        access(0, 1'b1, 2'd2, 1'b0, 32'h100 + (32'h1 << (AW + 2)), 32'h5A5A_A5A5);
        access(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        check("lit_alias", rd(0), 32'h5A5A_A5A5);

        // Inputs change while busy, and req stays high through DONE
        access(0, 1'b1, 2'd2, 1'b0, 32'h300, 32'h0BAD_F00D);
        start(0, 1'b1, 2'd2, 1'b0, 32'h108, 32'hCAFE_F00D);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h300, 32'h9999_9999);
        finish(0, 1'b1);
        repeat (2) @(negedge clk);
        access(0, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
        check("lit_busy_ignored", rd(0), 32'h0BAD_F00D);
        access(0, 1'b0, 2'd2, 1'b0, 32'h108, 32'h0);
        check("lit_latched", rd(0), 32'hCAFE_F00D);

        // Zero-wait instance
        access(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h1234_5678);
        access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("lit_w0_lw", rd(1), 32'h1234_5678);
        access(1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lit_w0_lb", rd(1), 32'h0000_0012);
        access(1, 1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        check("lit_w0_mis", er(1), 32'h1);

        // Reset in the middle of WAIT aborts the store
        access(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        access(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h0);
        start(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h0000_0055);
        @(negedge clk);
        #2 rst = 1'b0;
        pend[0] = 1'b0;
        set_req(0, 1'b0);
        #1;
        check("rst_mid_ready", 32'(i0.ready_o), 32'h0);
        check("rst_mid_busy",  32'(i0.busy_o), 32'h0);
        check("rst_mid_err",   32'(i0.addr_err_o), 32'h0);
        check("rst_mid_rdata", i0.rdata_o, 32'h0);
        @(posedge clk); #2 rst = 1'b1;
        access(0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        check("lit_abort", rd(0), 32'h0);
        access(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h0);
        access(0, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        check("lit_rst_lw", rd(0), 32'h0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
